noise_estimation_mc: RTL

Multi-channel, mode-selectable successor to the single-channel noise estimator. For each of CHANNELS interleaved pixel channels it computes the variance of every fixed-size block, then aggregates the block variances over a frame as either their minimum or their mean. It sits between the block scanner and the denoise-strength controller, and reports one noise estimate per channel per frame.

---
 rtl/noise_est_pkg.sv | 23 ++
 rtl/block_variance_acc.sv | 57 +++++
 rtl/noise_estimation_mc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/noise_est_pkg.sv
// Shared types and width helpers for the multi-channel noise estimator.
package noise_est_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_CALC,
    S_UPDATE,
    S_DONE
  } state_t;

  // A block variance occupies twice the sample width.
  localparam int VAR_WIDTH_FACTOR = 2;

  function automatic int log2_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int var_width(input int data_width);
    return VAR_WIDTH_FACTOR * data_width;
  endfunction

endpackage

// File: rtl/block_variance_acc.sv
// One channel's block accumulator: running sum and sum of squares, plus the
// registered variance computed from them once the block closes.
module block_variance_acc
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                take,
  input  logic                                calc,
  input  logic [DATA_WIDTH-1:0]               sample,
  output logic [var_width(DATA_WIDTH)-1:0]    variance
);

  localparam int L  = log2_width(TOTAL_SAMPLES);
  localparam int VW = var_width(DATA_WIDTH);
  localparam int SW = DATA_WIDTH + L;
  localparam int QW = 2 * DATA_WIDTH + L;

  logic [SW-1:0]         sum;
  logic [QW-1:0]         sumsq;
  logic [DATA_WIDTH-1:0] mean;
  logic [VW-1:0]         mean_sq;
  logic [VW-1:0]         ex2;
  logic [VW-1:0]         var_nxt;

  // Both moments are divided by the nominal block size even for short blocks.
  always_comb begin
    mean    = DATA_WIDTH'(sum >> L);
    mean_sq = VW'(mean) * VW'(mean);
    ex2     = VW'(sumsq >> L);
    var_nxt = (ex2 > mean_sq) ? (ex2 - mean_sq) : '0;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      sumsq    <= '0;
      variance <= '0;
    end else begin
      if (clear) begin
        sum   <= '0;
        sumsq <= '0;
      end else if (take) begin
        sum   <= sum + SW'(sample);
        sumsq <= sumsq + QW'(sample) * QW'(sample);
      end
      if (calc) variance <= var_nxt;
    end
  end

endmodule

// File: rtl/noise_estimation_mc.sv
// Multi-channel noise estimator: per-block variance per channel, reduced over
// a frame to the minimum or the mean, reported once per frame.
module noise_estimation_mc
  import noise_est_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int CHANNELS         = 3,
  parameter int TOTAL_SAMPLES    = 4,
  parameter int BLOCKS_PER_FRAME = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_of_frame,
  input  logic                             end_of_frame,
  input  logic                             start_data,
  input  logic                             end_data,
  input  logic                             data_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   data_in,
  input  logic                             mode,
  output logic [CHANNELS*2*DATA_WIDTH-1:0] estimated_noise,
  output logic                             estimated_noise_ready,
  output logic                             frame_error
);

  localparam int L  = log2_width(TOTAL_SAMPLES);
  localparam int B  = log2_width(BLOCKS_PER_FRAME);
  localparam int VW = var_width(DATA_WIDTH);
  localparam int CW = L + 1;
  localparam int BW = B + 2;
  localparam logic [CW-1:0] FULL_CNT   = CW'(TOTAL_SAMPLES);
  localparam logic [BW-1:0] EXP_BLOCKS = BW'(BLOCKS_PER_FRAME);

  state_t          state, state_nxt;
  logic            frame_open, mode_q, last_q, err_q;
  logic [CW-1:0]   sample_cnt, cnt_final;
  logic [BW-1:0]   block_cnt, block_cnt_inc;
  logic            frame_init, blk_clear, take, drop, end_blk;
  logic            calc_en, update_en, close_frame;
  logic [VW-1:0]   blk_var     [CHANNELS];
  logic [VW-1:0]   agg         [CHANNELS];
  logic [VW+B-1:0] agg_sum     [CHANNELS];
  logic [VW-1:0]   agg_min_nxt [CHANNELS];
  logic [VW+B-1:0] agg_sum_nxt [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    frame_init  = 1'b0;
    blk_clear   = 1'b0;
    take        = 1'b0;
    drop        = 1'b0;
    end_blk     = 1'b0;
    calc_en     = 1'b0;
    update_en   = 1'b0;
    close_frame = 1'b0;
    if (state != S_IDLE && start_of_frame) begin
      // A new frame start anywhere mid-frame aborts the one in progress.
      frame_init = 1'b1;
      blk_clear  = start_data;
      state_nxt  = start_data ? S_ACCUM : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_data && (start_of_frame || frame_open)) begin
            frame_init = start_of_frame;
            blk_clear  = 1'b1;
            state_nxt  = S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (start_data) begin
            blk_clear = 1'b1;
          end else begin
            take = data_valid && (sample_cnt < FULL_CNT);
            drop = data_valid && (sample_cnt >= FULL_CNT);
            if (end_data) begin
              end_blk   = 1'b1;
              state_nxt = S_CALC;
            end
          end
        end
        S_CALC: begin
          calc_en   = 1'b1;
          state_nxt = S_UPDATE;
        end
        S_UPDATE: begin
          update_en = 1'b1;
          state_nxt = last_q ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          close_frame = 1'b1;
          state_nxt   = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign cnt_final     = sample_cnt + CW'(take);
  assign block_cnt_inc = (&block_cnt) ? block_cnt : block_cnt + BW'(1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    block_variance_acc #(
      .DATA_WIDTH   (DATA_WIDTH),
      .TOTAL_SAMPLES(TOTAL_SAMPLES)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (blk_clear),
      .take    (take),
      .calc    (calc_en),
      .sample  (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .variance(blk_var[g])
    );
  end

  // The first block of a frame seeds the minimum directly.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      agg_min_nxt[c] = (block_cnt == '0 || blk_var[c] < agg[c]) ? blk_var[c] : agg[c];
      agg_sum_nxt[c] = agg_sum[c] + (VW+B)'(blk_var[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_open            <= 1'b0;
      mode_q                <= 1'b0;
      last_q                <= 1'b0;
      err_q                 <= 1'b0;
      sample_cnt            <= '0;
      block_cnt             <= '0;
      estimated_noise       <= '0;
      estimated_noise_ready <= 1'b0;
      frame_error           <= 1'b0;
      // NOTE: the aggregates are a handful of flops, not a RAM, so they take
      // the asynchronous reset like every other register.
      for (int c = 0; c < CHANNELS; c++) begin
        agg[c]     <= '0;
        agg_sum[c] <= '0;
      end
    end else begin
      estimated_noise_ready <= update_en && last_q;
      if (frame_init) begin
        frame_open <= 1'b1;
        mode_q     <= mode;
        err_q      <= 1'b0;
        block_cnt  <= '0;
      end
      if (close_frame) frame_open <= 1'b0;

      if (blk_clear)  sample_cnt <= '0;
      else if (take)  sample_cnt <= cnt_final;
      if (drop)       err_q      <= 1'b1;
      if (end_blk) begin
        last_q <= end_of_frame;
        if (cnt_final != FULL_CNT) err_q <= 1'b1;
      end

      if (update_en) begin
        block_cnt <= block_cnt_inc;
        if (last_q) frame_error <= err_q || (block_cnt_inc != EXP_BLOCKS);
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (frame_init) begin
          agg[c]     <= '0;
          agg_sum[c] <= '0;
        end else if (update_en) begin
          if (mode_q) agg_sum[c] <= agg_sum_nxt[c];
          else        agg[c]     <= agg_min_nxt[c];
          if (last_q)
            estimated_noise[c*VW +: VW] <= mode_q ? VW'(agg_sum_nxt[c] >> B) : agg_min_nxt[c];
        end
      end
    end
  end

endmodule
